pe_resp_id_tracker: RTL

- Slave-side endpoint of the peripheral interconnect; one instance per peripheral port, between the arbitration tree output and the peripheral.
- Records the one-hot master ID of every granted request in an in-order ID FIFO.
- Steers each peripheral response (r_valid, r_rdata) back to the issuing master as a one-hot valid vector, completing the backroute started by the PE request-side address decoder.

---
 rtl/pe_interco_pkg.sv | 19 +
 rtl/pe_id_fifo.sv | 88 ++++++++
 rtl/pe_resp_id_tracker.sv | 98 +++++++++
 3 files changed

// File: rtl/pe_interco_pkg.sv
// Shared definitions for the PE interconnect: master-ID type, default
// widths and helpers used by the slave-side response tracker.
package pe_interco_pkg;

  // Default number of masters; master IDs are one-hot across this many bits
  localparam int N_MASTER = 16;

  // Default response data width
  localparam int DATA_WIDTH = 32;

  // One-hot master identifier as carried through the arbitration tree
  typedef logic [N_MASTER-1:0] pe_id_t;

  // Width of an occupancy counter that must represent 0..depth inclusive
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pe_id_fifo.sv
// In-order FIFO of master IDs. One entry is written per granted request and
// one is consumed per peripheral response, so the head always names the
// master that owns the next response. Push and pop may happen in the same
// cycle at any occupancy where each is individually legal.
module pe_id_fifo
  import pe_interco_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type elem_t = pe_id_t,
  localparam int CW     = occ_width(DEPTH),
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  elem_t         wdata,
  output elem_t         rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  elem_t         r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  // Status flags come straight from the occupancy count, and requests are
  // qualified here too so that an overflowing push or an underflowing pop can
  // never corrupt the pointers even if the caller forgets to gate them
  always_comb begin
    w_full    = (r_count == DEPTH_CNT);
    w_empty   = (r_count == '0);
    w_do_push = push & ~w_full;
    w_do_pop  = pop & ~w_empty;
  end

  // Storage is written at the write pointer; contents need no reset because
  // the count alone decides which entries are meaningful
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  // Pointers wrap for free because DEPTH is a power of two, so there is no
  // bubble when an index rolls over
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  // Occupancy moves only when exactly one of push/pop happens
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rdata = r_mem[r_rptr];
  assign full  = w_full;
  assign empty = w_empty;
  assign count = r_count;

endmodule

// File: rtl/pe_resp_id_tracker.sv
// Slave-side endpoint of the PE interconnect. Remembers which master was
// granted each request and routes every in-order peripheral response back to
// that master as a one-hot valid vector, one cycle after the response arrives.
module pe_resp_id_tracker
  import pe_interco_pkg::*;
#(
  parameter int N_MASTER   = pe_interco_pkg::N_MASTER,
  parameter int DATA_WIDTH = pe_interco_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             data_req_i,
  input  logic [N_MASTER-1:0]              data_ID_i,
  output logic                             data_gnt_o,
  output logic                             data_req_o,
  input  logic                             data_gnt_i,
  input  logic                             data_r_valid_i,
  input  logic [DATA_WIDTH-1:0]            data_r_rdata_i,
  output logic [N_MASTER-1:0]              data_r_valid_o,
  output logic [DATA_WIDTH-1:0]            data_r_rdata_o,
  output logic [occ_width(FIFO_DEPTH)-1:0] outstanding_o,
  output logic                             err_o
);

  localparam int CW = occ_width(FIFO_DEPTH);

  typedef logic [N_MASTER-1:0] id_t;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_spurious;
  id_t           w_head_id;
  logic [CW-1:0] w_count;

  id_t                   r_valid_out;
  logic [DATA_WIDTH-1:0] r_rdata_out;
  logic                  r_err;

  // Request side: while every ID slot is taken, hide both the request and the
  // grant so nothing can be issued that we could not later route back. The
  // mask uses the current-cycle full flag, so a pop in the same cycle does
  // not open a pass-through path.
  always_comb begin
    data_req_o = data_req_i & ~w_full;
    data_gnt_o = data_gnt_i & ~w_full;
    w_push     = data_req_i & data_gnt_i & ~w_full;
    w_pop      = data_r_valid_i & ~w_empty;
    w_spurious = data_r_valid_i & w_empty;
  end

  pe_id_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .elem_t (id_t)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (data_ID_i),
    .rdata (w_head_id),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Response register: the valid vector is a one-cycle pulse carrying the
  // popped ID, while the data keeps its last value between responses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_out <= '0;
      r_rdata_out <= '0;
    end else begin
      r_valid_out <= w_pop ? w_head_id : '0;
      if (w_pop) begin
        r_rdata_out <= data_r_rdata_i;
      end
    end
  end

  // A response with nothing outstanding has no owner; flag it and keep the
  // flag until reset so software can find it after the fact
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_spurious) begin
      r_err <= 1'b1;
    end
  end

  assign data_r_valid_o = r_valid_out;
  assign data_r_rdata_o = r_rdata_out;
  assign outstanding_o  = w_count;
  assign err_o          = r_err;

endmodule
